// File: rtl/obi_mem_pkg.sv
// obi_mem_pkg: shared types and width helpers for the OBI memory responder.
//   obi_resp_t      response payload carried through the latency pipe
//   ObiDataW        payload data width (cv32e40p ports are 32 bits wide)
//   DefaultSeed     default stall-injection LFSR seed
//   be_width()      byte-enable width for a given data width
//   idx_width()     memory index width for a given depth
//   off_width()     number of byte-offset address bits below word granularity
package obi_mem_pkg;

    localparam int unsigned ObiDataW    = 32;
    localparam logic [15:0] DefaultSeed = 16'hACE1;

    typedef struct packed {
        logic [ObiDataW-1:0] rdata;
        logic                err;
    } obi_resp_t;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned off_width(input int unsigned be_w);
        return (be_w > 1) ? $clog2(be_w) : 0;
    endfunction

endpackage

// File: rtl/obi_mem_resp_pipe.sv
// obi_mem_resp_pipe: fixed-latency shift pipe for responses (valid + obi_resp_t).
// An entry loaded on a clock edge appears at the output Depth-1 edges later, so a
// Depth-deep pipe gives a response Depth cycles after the accept cycle.
//   clk_i    in   clock
//   rst_ni   in   asynchronous reset, active-high; clears every stage
//   valid_i  in   load a response into stage 0
//   resp_i   in   response payload
//   valid_o  out  last stage valid
//   resp_o   out  last stage payload (zero when not valid)
module obi_mem_resp_pipe
    import obi_mem_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      valid_i,
    input  obi_resp_t resp_i,
    output logic      valid_o,
    output obi_resp_t resp_o
);

    logic [Depth-1:0] valid_d, valid_q;
    obi_resp_t        resp_d [Depth];
    obi_resp_t        resp_q [Depth];

    always_comb begin
        valid_d[0] = valid_i;
        resp_d[0]  = valid_i ? resp_i : '0;
        for (int i = 1; i < Depth; i++) begin
            valid_d[i] = valid_q[i-1];
            resp_d[i]  = resp_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                resp_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < Depth; i++) begin
                resp_q[i] <= resp_d[i];
            end
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign resp_o  = resp_q[Depth-1];

endmodule

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI memory responder for one cv32e40p port (instr or data).
// Word-addressed memory with byte-enabled writes, fixed response latency, in-order
// responses and a bound on accepted-but-unanswered requests.
//   clk_i, rst_ni (asynchronous, active-high)
//   req_i / gnt_o                request handshake; gnt_o is combinational from req_i
//   addr_i, we_i, be_i, wdata_i  request payload
//   rvalid_o, rdata_o, err_o     response; rdata_o/err_o are zero while rvalid_o is low
// Optional build macro OBI_MEM_STALL_INJECT_EN enables LFSR-driven grant suppression.
module obi_mem_responder
    import obi_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W          = 32,
    parameter int unsigned       DATA_W          = ObiDataW,
    parameter int unsigned       DEPTH_WORDS     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
    parameter int unsigned       RVALID_LAT      = 1,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter logic [15:0]       STALL_SEED      = DefaultSeed
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic                   we_i,
    input  logic [DATA_W/8-1:0]    be_i,
    input  logic [DATA_W-1:0]      wdata_i,
    output logic                   rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   err_o
);

    localparam int unsigned BE_W  = be_width(DATA_W);
    localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
    localparam int unsigned OFF_W = off_width(BE_W);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic [ADDR_W-1:0] offset, word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              in_range, accept, stall;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    obi_resp_t         resp_in, resp_out;
    logic              pipe_valid;

    // Address decode: byte offset bits are dropped, so accesses are word-aligned.
    always_comb begin
        offset   = addr_i - BASE_ADDR;
        word_idx = offset >> OFF_W;
        in_range = (addr_i >= BASE_ADDR) && (word_idx < ADDR_W'(DEPTH_WORDS));
        mem_idx  = word_idx[IDX_W-1:0];
    end

`ifdef OBI_MEM_STALL_INJECT_EN
    logic [15:0] lfsr_d, lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall  = (lfsr_q[1:0] == 2'b00);
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // The count includes a response in its rvalid cycle, so a slot freed by that
    // response only becomes grantable on the following cycle.
    assign gnt_o  = ~rst_ni & req_i & (cnt_q < CNT_W'(MAX_OUTSTANDING)) & ~stall;
    assign accept = req_i & gnt_o;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, pipe_valid})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Memory is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        resp_in       = '0;
        resp_in.err   = ~in_range;
        resp_in.rdata = (!we_i && in_range) ? ObiDataW'(mem_q[mem_idx]) : '0;
    end

    obi_mem_resp_pipe #(
        .Depth (RVALID_LAT)
    ) u_resp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (accept),
        .resp_i  (resp_in),
        .valid_o (pipe_valid),
        .resp_o  (resp_out)
    );

    assign rvalid_o = pipe_valid;
    assign rdata_o  = pipe_valid ? DATA_W'(resp_out.rdata) : '0;
    assign err_o    = pipe_valid & resp_out.err;

endmodule

// File: tb/tb_obi_mem_responder.sv
module tb_obi_mem_responder;

    localparam int unsigned LAT   = 3;
    localparam int unsigned MAXO  = 2;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    obi_mem_responder #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .DEPTH_WORDS     (DEPTH),
        .BASE_ADDR       (32'h0),
        .RVALID_LAT      (LAT),
        .MAX_OUTSTANDING (MAXO),
        .STALL_SEED      (16'hACE1)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req),
        .gnt_o    (gnt_o),
        .addr_i   (addr),
        .we_i     (we),
        .be_i     (be),
        .wdata_i  (wdata),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one request until granted; acc is the cycle index of the accept cycle.
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (gnt_o) begin
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er, output int rvc,
                             output bit ok);
        ok = 1'b0; rd = 'x; er = 1'bx; rvc = -1;
        for (int i = 0; i < 20; i++) begin
            if (rvalid_o) begin
                rd = rdata_o; er = err_o; rvc = cyc; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (gnt_o !== 1'b0) begin
                errors++; $display("FAIL reset_gnt cycle %0d: got %b want 0", i, gnt_o);
            end
            checks++;
            if (rvalid_o !== 1'b0) begin
                errors++; $display("FAIL reset_rvalid cycle %0d: got %b want 0", i, rvalid_o);
            end
        end
        checks++;
        if (rdata_o !== 32'h0 || err_o !== 1'b0) begin
            errors++; $display("FAIL reset_rdata_err: got %h/%b want 0/0", rdata_o, err_o);
        end
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        checks++;
        if (gnt_o !== 1'b1) begin
            errors++; $display("FAIL reset_first_gnt: got %b want 1", gnt_o);
        end
        @(negedge clk);
        req = 1'b0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic do_txn(input string name, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_er);
        int acc, rvc;
        bit ok1, ok2;
        logic [31:0] rd;
        logic er;
        issue(w, a, b, d, acc, ok1);
        wait_resp(rd, er, rvc, ok2);
        checks++;
        if (!ok1 || !ok2) begin
            errors++; $display("FAIL %s_timeout: gnt_ok=%0d rvalid_ok=%0d want 1/1", name, ok1, ok2);
        end
        checks++;
        if (rvc - acc != LAT) begin
            errors++; $display("FAIL %s_latency: got %0d want %0d", name, rvc - acc, LAT);
        end
        checks++;
        if (rd !== exp_rd || er !== exp_er) begin
            errors++;
            $display("FAIL %s_data: got %h err=%b want %h err=%b", name, rd, er, exp_rd, exp_er);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        do_txn("wr_full", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        do_txn("rd_full", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        #1;
        checks++;
        if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: got rv=%b rd=%h err=%b want 0/0/0", rvalid_o, rdata_o, err_o);
        end
    endtask

    task automatic test_partial_write();
        do_txn("wr_part", 1'b1, 32'h10, 4'b0010, 32'h0000AA00, 32'h0, 1'b0);
        do_txn("rd_part", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF, 1'b0);
        do_txn("rd_unaligned", 1'b0, 32'h13, 4'h0, 32'h0, 32'hDEADAAEF, 1'b0);
    endtask

    // With req held and MAX=2, LAT=3, a response's slot is reusable only the cycle
    // after its rvalid, giving grants 1,1,0,0 repeating and rvalid in cycles 3,4,7.
    task automatic test_outstanding();
        logic [7:0] g, r;
        int out, max_out;
        bit data_bad;
        out = 0; max_out = 0; data_bad = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        for (int c = 0; c < 8; c++) begin
            #1;
            g[c] = gnt_o;
            r[c] = rvalid_o;
            if (rvalid_o && rdata_o !== 32'hDEADAAEF) data_bad = 1'b1;
            out = out + int'(gnt_o) - int'(rvalid_o);
            if (out > max_out) max_out = out;
            @(negedge clk);
        end
        req = 1'b0;
        checks++;
        if (g !== 8'b0011_0011) begin
            errors++; $display("FAIL outst_gnt_pattern: got %b want %b (bit0=first)", g, 8'b0011_0011);
        end
        checks++;
        if (r !== 8'b1001_1000) begin
            errors++; $display("FAIL outst_rvalid_pattern: got %b want %b", r, 8'b1001_1000);
        end
        checks++;
        if (max_out > int'(MAXO)) begin
            errors++; $display("FAIL outst_max: got %0d want <= %0d", max_out, MAXO);
        end
        checks++;
        if (data_bad) begin
            errors++; $display("FAIL outst_rdata: got bad data want DEADAAEF");
        end
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic test_range();
        do_txn("wr_word0", 1'b1, 32'h0, 4'hF, 32'h11111111, 32'h0, 1'b0);
        do_txn("wr_oob", 1'b1, 32'h4 * DEPTH, 4'hF, 32'h22222222, 32'h0, 1'b1);
        do_txn("rd_oob", 1'b0, 32'h4 * DEPTH, 4'h0, 32'h0, 32'h0, 1'b1);
        do_txn("rd_word0_kept", 1'b0, 32'h0, 4'h0, 32'h0, 32'h11111111, 1'b0);
        do_txn("rd_last", 1'b0, 32'h4 * (DEPTH - 1), 4'h0, 32'h0, 32'hx, 1'bx);
    endtask

    task automatic test_reset_mid_burst();
        int rv_seen;
        rv_seen = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rvalid_o) rv_seen++;
            @(negedge clk);
        end
        rst_ni = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (rvalid_o) rv_seen++;
            @(negedge clk);
        end
        checks++;
        if (rv_seen != 0) begin
            errors++; $display("FAIL reset_mid_burst: got %0d rvalids want 0", rv_seen);
        end
    endtask

`ifdef OBI_MEM_STALL_INJECT_EN
    task automatic test_stall_inject();
        logic [31:0] expq[$];
        int acc, resp, out, elig, stalls, order_bad, cycles;
        logic [31:0] a;
        acc = 0; resp = 0; out = 0; elig = 0; stalls = 0; order_bad = 0; cycles = 0;
        while (acc < 1000 && cycles < 6000) begin
            a = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h10;
            req = 1'b1; we = 1'b0; addr = a;
            #1;
            if (rvalid_o) begin
                if (expq.size() == 0 || rdata_o !== expq[0] || err_o !== 1'b0) order_bad++;
                if (expq.size() != 0) void'(expq.pop_front());
                resp++;
            end
            if (out < int'(MAXO)) begin
                elig++;
                if (!gnt_o) stalls++;
            end
            if (gnt_o) begin
                expq.push_back((a == 32'h0) ? 32'h11111111 : 32'hDEADAAEF);
                acc++;
            end
            out = out + int'(gnt_o) - int'(rvalid_o);
            @(negedge clk);
            cycles++;
        end
        req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rvalid_o) begin
                if (expq.size() == 0 || rdata_o !== expq[0]) order_bad++;
                if (expq.size() != 0) void'(expq.pop_front());
                resp++;
            end
            @(negedge clk);
        end
        checks++;
        if (acc != 1000) begin
            errors++; $display("FAIL stall_accepts: got %0d want 1000", acc);
        end
        checks++;
        if (resp != acc || order_bad != 0) begin
            errors++;
            $display("FAIL stall_responses: got %0d resp %0d bad want %0d resp 0 bad", resp, order_bad, acc);
        end
        checks++;
        if (stalls * 100 < elig * 15 || stalls * 100 > elig * 35) begin
            errors++; $display("FAIL stall_ratio: got %0d/%0d want about 25%%", stalls, elig);
        end
        test_reset_mid_burst();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_outstanding();
        test_range();
        test_reset_mid_burst();
`ifdef OBI_MEM_STALL_INJECT_EN
        test_stall_inject();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
